// File: rtl/fib_bcd_seq_pkg.sv
// Shared definitions for the BCD Fibonacci engine: state encoding,
// BCD digit width and the power-of-ten helper used to size the result limit.
package fib_bcd_seq_pkg;

   localparam int DIG_W = 4;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_FIB  = 3'd2,
      S_CONV = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // 10^n, evaluated at elaboration time to derive the largest representable result
   function automatic int pow10(input int n);
      int p;
      p = 1;
      for (int i = 0; i < n; i++) begin
         p = p * 10;
      end
      return p;
   endfunction

endpackage

// File: rtl/fib_bcd_seq_bcd_dd_conv.sv
// Serial binary-to-BCD converter (double dabble). A start pulse loads the
// binary operand; exactly BIN_W cycles later the result is presented together
// with a one-cycle done strobe. The result on done is the value after the final
// shift, so the consumer can capture it on that same edge.
module bcd_dd_conv
   import fib_bcd_seq_pkg::*;
#(
   parameter int N_DIG = 4,
   parameter int BIN_W = 14
) (
   input  logic                   clk,
   input  logic                   rst_b,
   input  logic                   start,
   input  logic [BIN_W-1:0]       bin,
   output logic                   done,
   output logic [DIG_W*N_DIG-1:0] bcd
);

   localparam int CW = $clog2(BIN_W + 1);

   logic [BIN_W-1:0]       bin_q;
   logic [DIG_W*N_DIG-1:0] bcd_q;
   logic [DIG_W*N_DIG-1:0] bcd_adj;
   logic [DIG_W*N_DIG-1:0] bcd_step;
   logic [CW-1:0]          cnt;
   logic                   busy;

   // add-3 correction on every digit >= 5, then shift in the next binary MSB
   always_comb begin
      bcd_adj = bcd_q;
      for (int k = 0; k < N_DIG; k++) begin
         if (bcd_q[DIG_W*k +: DIG_W] >= 4'd5) begin
            bcd_adj[DIG_W*k +: DIG_W] = bcd_q[DIG_W*k +: DIG_W] + 4'd3;
         end
      end
      bcd_step = (bcd_adj << 1) | {{(DIG_W*N_DIG-1){1'b0}}, bin_q[BIN_W-1]};
   end

   // shift register and down-counting cycle budget
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         bin_q <= '0;
         bcd_q <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
      end else if (start) begin
         bin_q <= bin;
         bcd_q <= '0;
         cnt   <= CW'(BIN_W);
         busy  <= 1'b1;
      end else if (busy) begin
         bcd_q <= bcd_step;
         bin_q <= bin_q << 1;
         cnt   <= cnt - CW'(1);
         if (cnt == CW'(1)) begin
            busy <= 1'b0;
         end
      end
   end

   assign done = busy && (cnt == CW'(1));
   assign bcd  = bcd_step;

endmodule

// File: rtl/fib_bcd_seq.sv
// BCD-in / BCD-out Fibonacci engine. The index arrives as N_DIG BCD digits,
// is folded to binary MSD first, F(n) is iterated with early overflow abort,
// and the binary result is converted back to BCD by the serial converter.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | ready for a start; inputs checked and latched on start
// LOAD  | one BCD digit per cycle folded into idx (MSD first)
// FIB   | one Fibonacci step per cycle; exits on idx==0 or overflow
// CONV  | serial binary-to-BCD conversion of the result (BIN_W cycles)
// DONE  | single-cycle result strobe, then back to IDLE
module fib_bcd_seq
   import fib_bcd_seq_pkg::*;
#(
   parameter int N_DIG = 4,
   parameter int BIN_W = 14
) (
   input  logic                   iCLK,
   input  logic                   iRESET_N,
   input  logic                   iSTART,
   input  logic [DIG_W*N_DIG-1:0] iBCD,
   output logic                   oREADY,
   output logic                   oDONE,
   output logic                   oOFLOW,
   output logic                   oERR,
   output logic [DIG_W*N_DIG-1:0] oBCD
);

   localparam int LIMIT = pow10(N_DIG) - 1;
   localparam int DC_W  = (N_DIG > 1) ? $clog2(N_DIG) : 1;
   localparam logic [BIN_W:0] LIMIT_W = (BIN_W + 1)'(LIMIT);

   // the binary datapath must hold every value up to LIMIT
   if ((2 ** BIN_W) <= LIMIT) begin : g_width_check
      $error("BIN_W too small for N_DIG");
   end

   state_t state, state_next;

   logic [DIG_W*N_DIG-1:0] bcd_in_q;
   logic [DIG_W*N_DIG-1:0] obcd_q;
   logic [DC_W-1:0]        dig_cnt;
   logic [BIN_W-1:0]       idx;
   logic [BIN_W-1:0]       t0;
   logic [BIN_W:0]         t1;
   logic                   oflow_q;
   logic                   err_q;

   logic                   digit_bad;
   logic [DIG_W-1:0]       load_digit;
   logic [BIN_W-1:0]       idx_load;
   logic [BIN_W:0]         t_sum;
   logic                   t1_over;
   logic                   conv_start;
   logic                   conv_done;
   logic [DIG_W*N_DIG-1:0] conv_bcd;

   // flag any non-decimal digit on the live input
   always_comb begin
      digit_bad = 1'b0;
      for (int k = 0; k < N_DIG; k++) begin
         if (iBCD[DIG_W*k +: DIG_W] > 4'd9) begin
            digit_bad = 1'b1;
         end
      end
   end

   // datapath arithmetic: digit fold, Fibonacci adder, overflow compare
   always_comb begin
      load_digit = bcd_in_q[DIG_W*dig_cnt +: DIG_W];
      idx_load   = idx * BIN_W'(10) + BIN_W'(load_digit);
      t_sum      = {1'b0, t0} + t1;
      t1_over    = (t1 > LIMIT_W);
      conv_start = (state == S_FIB) && (idx == '0);
   end

   // state register
   always_ff @(posedge iCLK) begin
      if (!iRESET_N) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // next-state logic and state-decoded outputs
   always_comb begin
      state_next = state;
      oREADY     = 1'b0;
      oDONE      = 1'b0;
      case (state)
         S_IDLE: begin
            oREADY = 1'b1;
            if (iSTART) begin
               state_next = digit_bad ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            if (dig_cnt == '0) begin
               state_next = S_FIB;
            end
         end
         S_FIB: begin
            if (idx == '0) begin
               state_next = S_CONV;
            end else if (t1_over) begin
               state_next = S_DONE;
            end
         end
         S_CONV: begin
            if (conv_done) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            oDONE      = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // working registers, result register and sticky flags
   always_ff @(posedge iCLK) begin
      if (!iRESET_N) begin
         bcd_in_q <= '0;
         obcd_q   <= '0;
         dig_cnt  <= '0;
         idx      <= '0;
         t0       <= '0;
         t1       <= '0;
         oflow_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (iSTART) begin
                  bcd_in_q <= iBCD;
                  oflow_q  <= 1'b0;
                  err_q    <= digit_bad;
                  dig_cnt  <= DC_W'(N_DIG - 1);
                  idx      <= '0;
                  if (digit_bad) begin
                     obcd_q <= '0;
                  end
               end
            end
            S_LOAD: begin
               idx     <= idx_load;
               dig_cnt <= dig_cnt - DC_W'(1);
               if (dig_cnt == '0) begin
                  t0 <= '0;
                  t1 <= (BIN_W + 1)'(1);
               end
            end
            S_FIB: begin
               if (idx != '0) begin
                  if (t1_over) begin
                     oflow_q <= 1'b1;
                     obcd_q  <= {N_DIG{4'h9}};
                  end else begin
                     t0  <= t1[BIN_W-1:0];
                     t1  <= t_sum;
                     idx <= idx - BIN_W'(1);
                  end
               end
            end
            S_CONV: begin
               if (conv_done) begin
                  obcd_q <= conv_bcd;
               end
            end
            default: begin
            end
         endcase
      end
   end

   bcd_dd_conv #(
      .N_DIG (N_DIG),
      .BIN_W (BIN_W)
   ) u_conv (
      .clk   (iCLK),
      .rst_b (iRESET_N),
      .start (conv_start),
      .bin   (t0),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   assign oBCD   = obcd_q;
   assign oOFLOW = oflow_q;
   assign oERR   = err_q;

endmodule
